// File: rtl/robot_pkg.sv
// Shared types and default parameter values for the waypoint sequencer.
package robot_pkg;

    localparam int unsigned DEF_DEPTH        = 8;
    localparam int unsigned DEF_COORD_W      = 16;
    localparam int unsigned DEF_START_CYCLES = 5;
    localparam int unsigned DEF_GAP_CYCLES   = 1;
    localparam int          DEF_COORD_LIMIT  = 1000;

    typedef logic signed [DEF_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } waypoint_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/waypoint_fifo.sv
// Synchronous waypoint FIFO with flush. The caller never pushes when full
// or pops when empty. Pop data is the current head, visible combinationally.
module waypoint_fifo
    import robot_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter type         T     = waypoint_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/waypoint_sequencer.sv
// Waypoint sequencer: buffers host waypoints and issues each one to the
// processor as a START_CYCLES-long start pulse followed by a GAP_CYCLES gap.
// Optional feature: define WAYPOINT_CLAMP_EN to saturate coordinates at pop.
module waypoint_sequencer
    import robot_pkg::*;
#(
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned COORD_W      = DEF_COORD_W,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int          COORD_LIMIT  = DEF_COORD_LIMIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wp_valid,
    output logic                       wp_ready,
    input  logic [COORD_W-1:0]         wp_x,
    input  logic [COORD_W-1:0]         wp_y,
    input  logic [COORD_W-1:0]         wp_z,
    input  logic                       flush,
    output logic [COORD_W-1:0]         target_x,
    output logic [COORD_W-1:0]         target_y,
    output logic [COORD_W-1:0]         target_z,
    output logic                       start,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       clamp_flag
);

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } wp_t;

    localparam int unsigned MAX_CYC = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

`ifdef WAYPOINT_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic signed [COORD_W-1:0] LIM_P = COORD_W'(COORD_LIMIT);
    localparam logic signed [COORD_W-1:0] LIM_N = -LIM_P;

    // Returns {saturated, value} for one signed coordinate.
    function automatic logic [COORD_W:0] sat(input logic signed [COORD_W-1:0] v);
        if (v > LIM_P) return {1'b1, LIM_P};
        if (v < LIM_N) return {1'b1, LIM_N};
        return {1'b0, v};
    endfunction

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             clamp_q, clamp_d;
    wp_t              target_q, target_d;

    wp_t              push_wp, head_wp, loaded_wp;
    logic             fifo_full, fifo_empty, push, pop, loaded_hit;
    logic [COORD_W:0] sx, sy, sz;

    assign wp_ready = !fifo_full && !flush;
    assign push     = wp_valid && wp_ready;
    assign push_wp  = '{x: wp_x, y: wp_y, z: wp_z};

    // Popping from GAP when its counter expires keeps back-to-back waypoints
    // at exactly START_CYCLES + GAP_CYCLES apart instead of idling one cycle.
    assign pop = !flush && !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0)));

    waypoint_fifo #(
        .DEPTH (DEPTH),
        .T     (wp_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_wp),
        .pop       (pop),
        .pop_data  (head_wp),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head waypoint as it will be loaded into the targets (optionally clamped).
    always_comb begin
        sx         = sat(head_wp.x);
        sy         = sat(head_wp.y);
        sz         = sat(head_wp.z);
        loaded_wp  = head_wp;
        loaded_hit = 1'b0;
        if (CLAMP_EN) begin
            loaded_wp.x = sx[COORD_W-1:0];
            loaded_wp.y = sy[COORD_W-1:0];
            loaded_wp.z = sz[COORD_W-1:0];
            loaded_hit  = sx[COORD_W] || sy[COORD_W] || sz[COORD_W];
        end
    end

    // Sequencing FSM: flush aborts, counters time DRIVE and GAP, pop loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        target_d = target_q;
        clamp_d  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            start_d = 1'b0;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (cnt_q == '0) begin
                        start_d = 1'b0;
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (pop) begin
                target_d = loaded_wp;
                start_d  = 1'b1;
                clamp_d  = loaded_hit;
                cnt_d    = CNT_W'(START_CYCLES - 1);
                state_d  = DRIVE;
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            clamp_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            clamp_q  <= clamp_d;
            target_q <= target_d;
        end
    end

    assign target_x   = target_q.x;
    assign target_y   = target_q.y;
    assign target_z   = target_q.z;
    assign start      = start_q;
    assign clamp_flag = clamp_q;
    assign busy       = (state_q != IDLE);

endmodule
